// File: rtl/execute.sv
// execute: RV32I EX stage (operand forwarding, ALU, jump/branch resolve, EX/MEM register).
// Latency: ex_mem__* one cycle; pipe_flush, ex_if__jump_target and ex__stall are combinational.
// Backpressure: a load-use hazard raises ex__stall for one cycle and registers a bubble while upstream holds id_ex.
module execute #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] id_ex__pc,
   input  logic [XLEN-1:0] id_ex__imm,
   input  logic [XLEN-1:0] id_ex__rs1_rdata,
   input  logic [XLEN-1:0] id_ex__rs2_rdata,
   input  logic [4:0]      id_ex__rs1_addr,
   input  logic [4:0]      id_ex__rs2_addr,
   input  logic [4:0]      id_ex__rd_addr,
   input  logic [3:0]      id_ex__alu_op,
   input  logic [1:0]      id_ex__alu_a_src,
   input  logic            id_ex__alu_b_src,
   input  logic [1:0]      id_ex__dmem_width,
   input  logic            id_ex__dmem_zero_ext,
   input  logic            id_ex__dmem_read,
   input  logic            id_ex__dmem_write,
   input  logic            id_ex__jump_base_src,
   input  logic [1:0]      id_ex__jump_cond,
   input  logic            id_ex__rd_wen,
   input  logic [1:0]      id_ex__rd_src,
   input  logic            wb_id__rd_wen,
   input  logic [4:0]      wb_id__rd_addr,
   input  logic [XLEN-1:0] wb_id__rd_wdata,
   output logic            pipe_flush,
   output logic [XLEN-1:0] ex_if__jump_target,
   output logic            ex__stall,
   output logic [XLEN-1:0] ex_mem__result,
   output logic [XLEN-1:0] ex_mem__rs2_wdata,
   output logic [4:0]      ex_mem__rd_addr,
   output logic            ex_mem__rd_wen,
   output logic            ex_mem__dmem_read,
   output logic            ex_mem__dmem_write,
   output logic            ex_mem__dmem_zero_ext,
   output logic [1:0]      ex_mem__rd_src,
   output logic [1:0]      ex_mem__dmem_width
);

   // Jump condition encodings shared with decode.
   localparam logic [1:0] COND_NEVER    = 2'd0;
   localparam logic [1:0] COND_ALWAYS   = 2'd1;
   localparam logic [1:0] COND_ZERO     = 2'd2;
   localparam logic [1:0] COND_NOT_ZERO = 2'd3;

   // rd_src value marking a load; its result is an address, not forwardable data.
   localparam logic [1:0] RD_SRC_DMEM = 2'd1;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] rs2_wdata;
      logic [4:0]      rd_addr;
      logic            rd_wen;
      logic            dmem_read;
      logic            dmem_write;
      logic            dmem_zero_ext;
      logic [1:0]      rd_src;
      logic [1:0]      dmem_width;
   } ex_mem_t;

   typedef enum logic {RUN, HOLD} state_t;

   ex_mem_t         em_q, em_d;
   state_t          state_q, state_d;
   logic            bubble;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu_a, alu_b, alu_res, base, jump_sum;
   logic [4:0]      shamt;
   logic            taken;

   // Per-operand forwarding: EX/MEM (non-load) beats WB, x0 never forwarded.
   always_comb begin
      rs1_fwd = id_ex__rs1_rdata;
      if (id_ex__rs1_addr != 5'd0 && em_q.rd_wen && em_q.rd_addr == id_ex__rs1_addr &&
          em_q.rd_src != RD_SRC_DMEM)
         rs1_fwd = em_q.result;
      else if (id_ex__rs1_addr != 5'd0 && wb_id__rd_wen && wb_id__rd_addr == id_ex__rs1_addr)
         rs1_fwd = wb_id__rd_wdata;
      rs2_fwd = id_ex__rs2_rdata;
      if (id_ex__rs2_addr != 5'd0 && em_q.rd_wen && em_q.rd_addr == id_ex__rs2_addr &&
          em_q.rd_src != RD_SRC_DMEM)
         rs2_fwd = em_q.result;
      else if (id_ex__rs2_addr != 5'd0 && wb_id__rd_wen && wb_id__rd_addr == id_ex__rs2_addr)
         rs2_fwd = wb_id__rd_wdata;
   end

   // Load in EX/MEM feeding either source of the instruction in EX.
   assign ex__stall = em_q.rd_wen && em_q.rd_src == RD_SRC_DMEM && em_q.rd_addr != 5'd0 &&
                      (em_q.rd_addr == id_ex__rs1_addr || em_q.rd_addr == id_ex__rs2_addr);

   // Operand select and ALU.
   always_comb begin
      case (id_ex__alu_a_src)
         2'd0:    alu_a = rs1_fwd;
         2'd1:    alu_a = id_ex__pc;
         default: alu_a = '0;
      endcase
      alu_b = id_ex__alu_b_src ? id_ex__imm : rs2_fwd;
      shamt = alu_b[4:0];
      case (id_ex__alu_op)
         4'd0:    alu_res = alu_a + alu_b;
         4'd1:    alu_res = alu_a - alu_b;
         4'd2:    alu_res = alu_a << shamt;
         4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
         4'd4:    alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
         4'd5:    alu_res = alu_a ^ alu_b;
         4'd6:    alu_res = alu_a >> shamt;
         4'd7:    alu_res = $signed(alu_a) >>> shamt;
         4'd8:    alu_res = alu_a | alu_b;
         4'd9:    alu_res = alu_a & alu_b;
         default: alu_res = '0;
      endcase
   end

   // Jump target and taken decision; a stalled jump waits for HOLD's correct operands.
   always_comb begin
      base     = id_ex__jump_base_src ? rs1_fwd : id_ex__pc;
      jump_sum = base + id_ex__imm;
      case (id_ex__jump_cond)
         COND_NEVER:    taken = 1'b0;
         COND_ALWAYS:   taken = 1'b1;
         COND_ZERO:     taken = (alu_res == '0);
         COND_NOT_ZERO: taken = (alu_res != '0);
         default:       taken = 1'b0;
      endcase
   end

   assign ex_if__jump_target = jump_sum & {{(XLEN-1){1'b1}}, 1'b0};
   assign pipe_flush         = taken && !ex__stall;

   // Stall FSM: one bubble on entering HOLD, then re-execute the held instruction.
   always_comb begin
      state_d = state_q;
      bubble  = 1'b0;
      case (state_q)
         RUN: begin
            if (ex__stall) begin
               bubble  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Next EX/MEM contents; a bubble drops every side-effecting strobe.
   always_comb begin
      em_d.rs2_wdata     = rs2_fwd;
      em_d.rd_addr       = id_ex__rd_addr;
      em_d.rd_wen        = id_ex__rd_wen && !bubble;
      em_d.dmem_read     = id_ex__dmem_read && !bubble;
      em_d.dmem_write    = id_ex__dmem_write && !bubble;
      em_d.dmem_zero_ext = id_ex__dmem_zero_ext;
      em_d.rd_src        = id_ex__rd_src;
      em_d.dmem_width    = id_ex__dmem_width;
      case (id_ex__rd_src)
         2'd2:    em_d.result = id_ex__pc + XLEN'(4);
         2'd3:    em_d.result = id_ex__imm;
         default: em_d.result = alu_res;
      endcase
   end

   // State and EX/MEM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         em_q    <= '0;
      end else begin
         state_q <= state_d;
         em_q    <= em_d;
      end
   end

   assign ex_mem__result        = em_q.result;
   assign ex_mem__rs2_wdata     = em_q.rs2_wdata;
   assign ex_mem__rd_addr       = em_q.rd_addr;
   assign ex_mem__rd_wen        = em_q.rd_wen;
   assign ex_mem__dmem_read     = em_q.dmem_read;
   assign ex_mem__dmem_write    = em_q.dmem_write;
   assign ex_mem__dmem_zero_ext = em_q.dmem_zero_ext;
   assign ex_mem__rd_src        = em_q.rd_src;
   assign ex_mem__dmem_width    = em_q.dmem_width;

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage RV32I pipeline. It consumes the `id_ex__*` bundle registered by decode and resolves operand forwarding from the memory and writeback stages. It computes the ALU result and the jump/branch outcome, drives `pipe_flush` back to fetch and decode, and registers the `ex_mem__*` bundle for the memory stage. It also detects load-use hazards and inserts a one-cycle bubble.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_ex__pc`  in  32  PC of the instruction in EX.
- `id_ex__imm`, `id_ex__rs1_rdata`, `id_ex__rs2_rdata`  in  32 each  immediate and register-file read data.
- `id_ex__rs1_addr`, `id_ex__rs2_addr`, `id_ex__rd_addr`  in  5 each  register addresses.
- `id_ex__alu_op`  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10–15 give result 0.
- `id_ex__alu_a_src`  in  2  0 rs1, 1 pc, 2 and 3 zero.
- `id_ex__alu_b_src`  in  1  0 rs2, 1 imm.
- `id_ex__dmem_width`  in  2  memory access width, passed through.
- `id_ex__dmem_zero_ext`  in  1  load zero-extension, passed through.
- `id_ex__dmem_read`, `id_ex__dmem_write`  in  1 each  memory access strobes.
- `id_ex__jump_base_src`  in  1  0 pc, 1 rs1.
- `id_ex__jump_cond`  in  2  jump.vh encodings: `COND_NEVER`, `COND_ALWAYS`, `COND_ZERO` (taken when ALU result == 0), `COND_NOT_ZERO`.
- `id_ex__rd_wen`  in  1  destination write enable.
- `id_ex__rd_src`  in  2  0 ALU, 1 dmem, 2 pc+4, 3 imm.
- `wb_id__rd_wen`, `wb_id__rd_addr`, `wb_id__rd_wdata`  in  1/5/32  writeback forwarding source.
- `pipe_flush`  out  1  taken jump; kills the ID instruction and redirects fetch.
- `ex_if__jump_target`  out  32  redirect address; valid when `pipe_flush` is high.
- `ex__stall`  out  1  load-use stall; fetch and decode hold state.
- `ex_mem__result`, `ex_mem__rs2_wdata`  out  32 each  registered result and store data.
- `ex_mem__rd_addr`  out  5  registered destination address.
- `ex_mem__rd_wen`, `ex_mem__dmem_read`, `ex_mem__dmem_write`, `ex_mem__dmem_zero_ext`  out  1 each  registered controls.
- `ex_mem__rd_src`, `ex_mem__dmem_width`  out  2 each  registered controls.

## Operation
- **Forwarding**, evaluated per operand. If `ex_mem__rd_wen && ex_mem__rd_addr == rsN_addr && rsN_addr != 0 && ex_mem__rd_src != 1`, use `ex_mem__result`. Otherwise, if `wb_id__rd_wen && wb_id__rd_addr == rsN_addr && rsN_addr != 0`, use `wb_id__rd_wdata`. Otherwise use `id_ex__rsN_rdata`. EX/MEM takes priority over WB.
- **Load-use hazard**: `ex__stall = ex_mem__rd_wen && ex_mem__rd_src == 1 && ex_mem__rd_addr != 0 && ex_mem__rd_addr matches rs1_addr or rs2_addr`.
- **Shifts** use `b[4:0]`. SLT is signed; SLTU is unsigned. All arithmetic wraps modulo 2^32.
- **Jumps**:
  - `base` = pc when `jump_base_src` = 0, forwarded rs1 when 1.
  - `ex_if__jump_target = (base + imm) & ~1`.
  - `taken` is decided by `jump_cond` applied to the ALU result.
  - `pipe_flush = taken && !ex__stall`.
- **Result mux**: ALU result (rd_src 0 or 1), `pc + 4` (rd_src 2), or `imm` (rd_src 3). For rd_src 1 the memory stage uses `result` as the address.
- **Store data**: `ex_mem__rs2_wdata` is the forwarded rs2.
- **Stall FSM**, two states:
  - RUN: on `ex__stall`, register a bubble (`rd_wen`, `dmem_read`, `dmem_write` = 0) and go to HOLD.
  - HOLD: upstream has held `id_ex__*`, and the load is now in WB, so forwarding resolves. Register normally and return to RUN.
  - A stall cannot re-trigger in HOLD because `ex_mem` holds a bubble.

## Timing
- **Reset** (asynchronous, `rst_n` low):
  - all `ex_mem__*` = 0 and the FSM goes to RUN;
  - `pipe_flush`, `ex__stall` and `ex_if__jump_target` then follow their combinational definitions from the inputs and the cleared `ex_mem__rd_wen = 0`;
  - reset asserted mid-stall returns to RUN with no bubble pending.
- **Combinational outputs**: `pipe_flush`, `ex_if__jump_target` and `ex__stall` are combinational from the current inputs and registers, valid in the same cycle.
- **Latency**: `ex_mem__*` has 1-cycle latency. A load-use pair costs exactly one bubble cycle.
- **Flush**: a taken jump registers its own `ex_mem` normally (e.g. the rd link). The decode-side flush zeroes the following instruction's strobes.
- **Simultaneous stall and taken**: flush is suppressed and re-evaluated in HOLD with the correct operands.

## Test plan
- **ALU**: ADD with rs1 = 0x7FFFFFFF, imm = 1 (`alu_b_src` = 1) -> `ex_mem__result` = 0x80000000 one cycle later. SRA of 0x80000000 by 4 -> 0xF8000000.
- **Forwarding**: back-to-back `x5` writer (result 0x11) then `x5` reader. Forwarded operand = 0x11 and beats a simultaneous WB `x5` = 0x22. Address `x0` is never forwarded (operand = rdata).
- **Load-use**: load to `x7` in `ex_mem`, EX reads `x7` -> `ex__stall` = 1 for one cycle, bubble registered (`rd_wen` = 0). Next cycle uses the WB data 0xDEADBEEF.
- **Branch**: SUB, `COND_ZERO`, pc = 0x100, imm = 0x20, equal operands -> `pipe_flush` = 1, target 0x120. Unequal operands -> `pipe_flush` = 0.
- **JALR**: rs1 = 0x203, imm = 0, `COND_ALWAYS`, `rd_src` 2, pc = 0x40 -> target 0x202, `ex_mem__result` = 0x44.
- **Reset**: assert `rst_n` = 0 during HOLD -> all `ex_mem__*` = 0 immediately, and RUN after release.
